alarm_sequencer: RTL and testbench

- Top-level controller for the security system. Sequences the arming delay, entry delay and siren timing from one shared countdown timer.
- Arbitrates ZONES sensor inputs into a single intrusion event.
- Sits between the keypad/code-check logic (arm/disarm pulses) and the siren/indicator drivers.
- Replaces per-state ad-hoc timers with one reloadable counter owned by this FSM.

---
 rtl/alarm_sequencer.sv | 114 +++++++++++
 tb/tb_alarm_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
`default_nettype none
// alarm_sequencer: exit/entry/siren sequencing from one shared countdown timer,
// with synchronized, enable-masked zone inputs.  Rev 1.0
module alarm_sequencer #(
  parameter int ZONES     = 4,
  parameter int CNT_W     = 16,
  parameter int EXIT_CYC  = 100,
  parameter int ENTRY_CYC = 50,
  parameter int SIREN_CYC = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             disarm,
  input  logic [ZONES-1:0] zone,
  input  logic [ZONES-1:0] zone_en,
  output logic [2:0]       state,
  output logic             siren,
  output logic             armed_led,
  output logic [ZONES-1:0] alarm_zone,
  output logic [CNT_W-1:0] tmr_cnt
);

  typedef enum logic [2:0] {
    DISARMED = 3'd0,
    EXIT     = 3'd1,
    ARMED    = 3'd2,
    ENTRY    = 3'd3,
    ALARM    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_CYC - 1);
  localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           cur_state, nxt_state;
  logic [ZONES-1:0] sync1, sync2, zs;
  logic             hit;
  logic [CNT_W-1:0] tmr_nxt;
  logic [ZONES-1:0] az_nxt;

  assign zs    = sync2 & zone_en;
  assign hit   = |zs;
  assign state = cur_state;

  always_comb begin
    nxt_state = cur_state;
    tmr_nxt   = '0;
    az_nxt    = alarm_zone;
    if (disarm) begin
      nxt_state = DISARMED;
    end else begin
      case (cur_state)
        DISARMED: begin
          if (arm) begin
            nxt_state = EXIT;
            tmr_nxt   = EXIT_LD;
            az_nxt    = '0;
          end
        end
        EXIT: begin
          if (tmr_cnt == '0) nxt_state = ARMED;
          else               tmr_nxt   = tmr_cnt - ONE;
        end
        ARMED: begin
          if (hit) begin
            nxt_state = ENTRY;
            tmr_nxt   = ENTRY_LD;
            az_nxt    = alarm_zone | zs;
          end
        end
        ENTRY: begin
          az_nxt = alarm_zone | zs;
          if (tmr_cnt == '0) begin
            nxt_state = ALARM;
            tmr_nxt   = SIREN_LD;
          end else begin
            tmr_nxt = tmr_cnt - ONE;
          end
        end
        ALARM: begin
          az_nxt = alarm_zone | zs;
          // Expiry re-arms; a still-tripped zone re-enters ENTRY from ARMED.
          if (tmr_cnt == '0) nxt_state = ARMED;
          else               tmr_nxt   = tmr_cnt - ONE;
        end
        default: nxt_state = DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync2      <= '0;
      cur_state  <= DISARMED;
      tmr_cnt    <= '0;
      alarm_zone <= '0;
      siren      <= 1'b0;
      armed_led  <= 1'b0;
    end else begin
      sync1      <= zone;
      sync2      <= sync1;
      cur_state  <= nxt_state;
      tmr_cnt    <= tmr_nxt;
      alarm_zone <= az_nxt;
      siren      <= (nxt_state == ALARM);
      armed_led  <= (nxt_state != DISARMED);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// tb_alarm_sequencer: table-driven vectors with an expected-value queue.
// Rev 1.0
module tb_alarm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm, disarm;
  logic [3:0]  zone, zone_en;
  logic [2:0]  state;
  logic        siren, armed_led;
  logic [3:0]  alarm_zone;
  logic [15:0] tmr_cnt;

  typedef struct {
    logic        arm;
    logic        disarm;
    logic [3:0]  zone;
    logic [3:0]  zone_en;
    logic [2:0]  st;
    logic        siren;
    logic        led;
    logic [3:0]  az;
    logic [15:0] tmr;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  alarm_sequencer #(
    .ZONES(4), .CNT_W(16), .EXIT_CYC(4), .ENTRY_CYC(3), .SIREN_CYC(5)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .disarm(disarm),
    .zone(zone), .zone_en(zone_en), .state(state), .siren(siren),
    .armed_led(armed_led), .alarm_zone(alarm_zone), .tmr_cnt(tmr_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t V(input logic a, input logic d,
                             input logic [3:0] z, input logic [3:0] en,
                             input logic [2:0] s, input logic sr, input logic l,
                             input logic [3:0] az, input logic [15:0] t);
    vec_t v;
    v.arm = a; v.disarm = d; v.zone = z; v.zone_en = en;
    v.st = s; v.siren = sr; v.led = l; v.az = az; v.tmr = t;
    return v;
  endfunction

  task automatic compare_front(input string name);
    vec_t e;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    vectors++;
    if ({state, siren, armed_led, alarm_zone, tmr_cnt} !==
        {e.st, e.siren, e.led, e.az, e.tmr}) begin
      miscompares++;
      $display("FAIL %s: got state=%0d siren=%b led=%b az=%b tmr=%0d, expected state=%0d siren=%b led=%b az=%b tmr=%0d",
               name, state, siren, armed_led, alarm_zone, tmr_cnt,
               e.st, e.siren, e.led, e.az, e.tmr);
    end
  endtask

  task automatic step(input vec_t v, input string name);
    @(negedge clk);
    arm = v.arm; disarm = v.disarm; zone = v.zone; zone_en = v.zone_en;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    compare_front(name);
  endtask

  initial begin
    // Main flow: arm, exit delay, trip, entry, siren, auto re-arm, disarm,
    // masked zone, multi-zone capture, disarm mid-alarm, re-arm clears record.
    tbl.push_back(V(0,0,4'b0000,4'b0011, 0,0,0,4'b0000,0));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 0,0,0,4'b0000,0));
    tbl.push_back(V(1,0,4'b0000,4'b0011, 1,0,1,4'b0000,3));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 1,0,1,4'b0000,2));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 1,0,1,4'b0000,1));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 1,0,1,4'b0000,0));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 2,0,1,4'b0000,0));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 2,0,1,4'b0000,0));
    tbl.push_back(V(1,0,4'b0000,4'b0011, 2,0,1,4'b0000,0));
    tbl.push_back(V(0,0,4'b0010,4'b0011, 2,0,1,4'b0000,0));
    tbl.push_back(V(0,0,4'b0010,4'b0011, 2,0,1,4'b0000,0));
    tbl.push_back(V(0,0,4'b0010,4'b0011, 3,0,1,4'b0010,2));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 3,0,1,4'b0010,1));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 3,0,1,4'b0010,0));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 4,1,1,4'b0010,4));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 4,1,1,4'b0010,3));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 4,1,1,4'b0010,2));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 4,1,1,4'b0010,1));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 4,1,1,4'b0010,0));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 2,0,1,4'b0010,0));
    tbl.push_back(V(0,0,4'b0000,4'b0011, 2,0,1,4'b0010,0));
    tbl.push_back(V(0,1,4'b0000,4'b0011, 0,0,0,4'b0010,0));
    tbl.push_back(V(1,1,4'b0000,4'b0011, 0,0,0,4'b0010,0));
    tbl.push_back(V(1,0,4'b1000,4'b0111, 1,0,1,4'b0000,3));
    tbl.push_back(V(0,0,4'b1000,4'b0111, 1,0,1,4'b0000,2));
    tbl.push_back(V(0,0,4'b1000,4'b0111, 1,0,1,4'b0000,1));
    tbl.push_back(V(0,0,4'b1000,4'b0111, 1,0,1,4'b0000,0));
    tbl.push_back(V(0,0,4'b1000,4'b0111, 2,0,1,4'b0000,0));
    tbl.push_back(V(0,0,4'b1000,4'b0111, 2,0,1,4'b0000,0));
    tbl.push_back(V(0,0,4'b1010,4'b0111, 2,0,1,4'b0000,0));
    tbl.push_back(V(0,0,4'b1010,4'b0111, 2,0,1,4'b0000,0));
    tbl.push_back(V(0,0,4'b1011,4'b0111, 3,0,1,4'b0010,2));
    tbl.push_back(V(0,0,4'b1011,4'b0111, 3,0,1,4'b0010,1));
    tbl.push_back(V(0,0,4'b1011,4'b0111, 3,0,1,4'b0011,0));
    tbl.push_back(V(0,0,4'b1011,4'b0111, 4,1,1,4'b0011,4));
    tbl.push_back(V(0,0,4'b1011,4'b0111, 4,1,1,4'b0011,3));
    tbl.push_back(V(0,1,4'b1011,4'b0111, 0,0,0,4'b0011,0));
    tbl.push_back(V(0,0,4'b1011,4'b0111, 0,0,0,4'b0011,0));
    tbl.push_back(V(0,0,4'b0000,4'b0111, 0,0,0,4'b0011,0));
    tbl.push_back(V(1,0,4'b0000,4'b0111, 1,0,1,4'b0000,3));
    tbl.push_back(V(0,0,4'b0000,4'b0111, 1,0,1,4'b0000,2));
    tbl.push_back(V(0,0,4'b0000,4'b0111, 1,0,1,4'b0000,1));
    tbl.push_back(V(0,0,4'b0000,4'b0111, 1,0,1,4'b0000,0));
    tbl.push_back(V(0,0,4'b0000,4'b0111, 2,0,1,4'b0000,0));

    reset = 1'b0; arm = 1'b0; disarm = 1'b0; zone = '0; zone_en = '0;
    #3;
    exp_q.push_back(V(0,0,0,0, 0,0,0,0,0));
    compare_front("reset_state");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // Held zone: ALARM expires to ARMED then straight back into ENTRY.
    step(V(0,0,4'b0100,4'b0111, 2,0,1,4'b0000,0), "hold_sync1");
    step(V(0,0,4'b0100,4'b0111, 2,0,1,4'b0000,0), "hold_sync2");
    step(V(0,0,4'b0100,4'b0111, 3,0,1,4'b0100,2), "hold_entry");
    step(V(0,0,4'b0100,4'b0111, 3,0,1,4'b0100,1), "hold_entry1");
    step(V(0,0,4'b0100,4'b0111, 3,0,1,4'b0100,0), "hold_entry0");
    for (int k = 4; k >= 0; k--)
      step(V(0,0,4'b0100,4'b0111, 4,1,1,4'b0100,16'(k)), $sformatf("hold_alarm%0d", k));
    step(V(0,0,4'b0100,4'b0111, 2,0,1,4'b0100,0), "rearm");
    step(V(0,0,4'b0100,4'b0111, 3,0,1,4'b0100,2), "reentry");
    step(V(0,0,4'b0100,4'b0111, 3,0,1,4'b0100,1), "reentry1");
    step(V(0,0,4'b0100,4'b0111, 3,0,1,4'b0100,0), "reentry0");
    step(V(0,0,4'b0100,4'b0111, 4,1,1,4'b0100,4), "realarm");

    // Asynchronous reset between edges must clear everything immediately.
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(V(0,0,0,0, 0,0,0,0,0));
    compare_front("async_reset");
    step(V(0,0,4'b0100,4'b0111, 0,0,0,4'b0000,0), "reset_held");
    reset = 1'b1;
    step(V(0,0,4'b0000,4'b0111, 0,0,0,4'b0000,0), "post_reset");
    step(V(1,0,4'b0000,4'b0111, 1,0,1,4'b0000,3), "post_reset_arm");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
